// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point subtractor arbiter: width helpers
// and the arbiter FSM state encoding.
package fixed_point_pkg;

    // Arbiter FSM: grant in IDLE, compute in EXEC, present result in RESP.
    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_EXEC = 2'd1,
        STATE_RESP = 2'd2
    } state_t;

    // Total operand/result width from the integer and fractional parts.
    function automatic int calc_number_width(input int integer_bits, input int fractional_bits);
        return integer_bits + fractional_bits;
    endfunction

    // Requester index width; never below one bit so ports stay legal.
    function automatic int calc_id_width(input int requester_count);
        return (requester_count < 2) ? 1 : $clog2(requester_count);
    endfunction

endpackage

// File: rtl/fixed_point_sub.sv
// Combinational two's-complement fixed-point subtractor. The binary point of
// the result is that of the operands; out-of-range differences wrap modulo
// 2^NUMBER_WIDTH.
module fixed_point_sub
    import fixed_point_pkg::*;
#(
    parameter int INTEGER_PART_WIDTH    = 3,
    parameter int FRACTIONAL_PART_WIDTH = 2,
    localparam int NUMBER_WIDTH = calc_number_width(INTEGER_PART_WIDTH, FRACTIONAL_PART_WIDTH)
) (
    input  logic signed [NUMBER_WIDTH-1:0] a,
    input  logic signed [NUMBER_WIDTH-1:0] b,
    output logic signed [NUMBER_WIDTH-1:0] result
);

    // Difference truncated to the operand width, i.e. modular wrap-around.
    function automatic logic signed [NUMBER_WIDTH-1:0] wrap_sub(
        input logic signed [NUMBER_WIDTH-1:0] x,
        input logic signed [NUMBER_WIDTH-1:0] y
    );
        logic signed [NUMBER_WIDTH:0] full;
        full = {x[NUMBER_WIDTH-1], x} - {y[NUMBER_WIDTH-1], y};
        return full[NUMBER_WIDTH-1:0];
    endfunction

    assign result = wrap_sub(a, b);

endmodule

// File: rtl/fixed_point_sub_arbiter.sv
// Round-robin arbiter sharing a single fixed_point_sub among REQUESTER_COUNT
// requesters. Each accepted operation returns one registered result tagged
// with the issuing requester's index.
// Optional feature macro: FIXED_POINT_SUB_ARBITER_OVERFLOW_EN adds the
// resp_overflow output, registered alongside resp_result.
module fixed_point_sub_arbiter
    import fixed_point_pkg::*;
#(
    parameter int INTEGER_PART_WIDTH    = 3,
    parameter int FRACTIONAL_PART_WIDTH = 2,
    parameter int REQUESTER_COUNT       = 4,
    localparam int NUMBER_WIDTH = calc_number_width(INTEGER_PART_WIDTH, FRACTIONAL_PART_WIDTH),
    localparam int ID_WIDTH     = calc_id_width(REQUESTER_COUNT)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [REQUESTER_COUNT-1:0]              req_valid,
    output logic [REQUESTER_COUNT-1:0]              req_ready,
    input  logic [REQUESTER_COUNT*NUMBER_WIDTH-1:0] req_a,
    input  logic [REQUESTER_COUNT*NUMBER_WIDTH-1:0] req_b,
    output logic                                    resp_valid,
    input  logic                                    resp_ready,
    output logic [NUMBER_WIDTH-1:0]                 resp_result,
    output logic [ID_WIDTH-1:0]                     resp_id
`ifdef FIXED_POINT_SUB_ARBITER_OVERFLOW_EN
    ,
    output logic                                    resp_overflow
`endif
);

    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(REQUESTER_COUNT - 1);

    state_t                         state;
    logic [ID_WIDTH-1:0]            rr_ptr;

    logic                           grant_found;
    logic [ID_WIDTH-1:0]            grant_idx;
    logic                           grant_fire;

    logic signed [NUMBER_WIDTH-1:0] a_p0;
    logic signed [NUMBER_WIDTH-1:0] b_p0;
    logic [ID_WIDTH-1:0]            id_p0;
    logic signed [NUMBER_WIDTH-1:0] diff_p1;

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < REQUESTER_COUNT; k++) begin
            idx = (int'(rr_ptr) + k) % REQUESTER_COUNT;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_WIDTH'(idx);
            end
        end
    end

    // A grant is only offered while idle and never while reset is asserted.
    assign grant_fire = (state == STATE_IDLE) && grant_found && !rst;

    // One-hot ready toward the winning requester, zero otherwise.
    always_comb begin
        req_ready = '0;
        if (grant_fire) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // ---- stage p0: operands and issuer captured at the handshake ----
    // Operand capture; pure data, so no reset is needed.
    always_ff @(posedge clk) begin
        if (grant_fire) begin
            a_p0  <= req_a[grant_idx*NUMBER_WIDTH +: NUMBER_WIDTH];
            b_p0  <= req_b[grant_idx*NUMBER_WIDTH +: NUMBER_WIDTH];
            id_p0 <= grant_idx;
        end
    end

    // ---- stage p1: shared subtractor output, registered in EXEC ----
    fixed_point_sub #(
        .INTEGER_PART_WIDTH    (INTEGER_PART_WIDTH),
        .FRACTIONAL_PART_WIDTH (FRACTIONAL_PART_WIDTH)
    ) u_sub (
        .a      (a_p0),
        .b      (b_p0),
        .result (diff_p1)
    );

`ifdef FIXED_POINT_SUB_ARBITER_OVERFLOW_EN
    // Signed overflow: operand signs differ and the result sign departs from a.
    function automatic logic sub_overflow(
        input logic signed [NUMBER_WIDTH-1:0] x,
        input logic signed [NUMBER_WIDTH-1:0] y,
        input logic signed [NUMBER_WIDTH-1:0] r
    );
        return (x[NUMBER_WIDTH-1] != y[NUMBER_WIDTH-1]) &&
               (r[NUMBER_WIDTH-1] != x[NUMBER_WIDTH-1]);
    endfunction

    // Overflow flag registered together with the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_overflow <= 1'b0;
        end else if (state == STATE_EXEC) begin
            resp_overflow <= sub_overflow(a_p0, b_p0, diff_p1);
        end
    end
`else
    // No overflow tracking in this build; resp_overflow does not exist.
`endif

    // Arbiter FSM with registered response outputs and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= STATE_IDLE;
            rr_ptr      <= '0;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_id     <= '0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (grant_fire) begin
                        state <= STATE_EXEC;
                    end
                end
                STATE_EXEC: begin
                    resp_result <= diff_p1;
                    resp_id     <= id_p0;
                    resp_valid  <= 1'b1;
                    state       <= STATE_RESP;
                end
                STATE_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        rr_ptr     <= (resp_id == LAST_ID) ? '0 : resp_id + ID_WIDTH'(1);
                        state      <= STATE_IDLE;
                    end
                end
                default: begin
                    state      <= STATE_IDLE;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
